// File: rtl/mtm_alu_pkg.sv
// Shared types and constants for the two-channel mtm_Alu_core arbiter.
package mtm_alu_pkg;

  localparam int DATA_W = 32;
  localparam int CTL_W  = 8;

  localparam logic [CTL_W-1:0] TIMEOUT_CTL_DEF = 8'hC9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mtm_alu_core_arbiter_if.sv
// Request, core and response signals between requesters, arbiter and core.
interface mtm_alu_core_arbiter_if;
  import mtm_alu_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_A;
  logic [DATA_W-1:0] req0_B;
  logic [CTL_W-1:0]  req0_CTL;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_A;
  logic [DATA_W-1:0] req1_B;
  logic [CTL_W-1:0]  req1_CTL;

  logic              core_start;
  logic [DATA_W-1:0] core_A;
  logic [DATA_W-1:0] core_B;
  logic [CTL_W-1:0]  core_CTL;
  logic              core_done;
  logic [DATA_W-1:0] core_C;
  logic [CTL_W-1:0]  core_CTL_out;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp_C;
  logic [CTL_W-1:0]  rsp_CTL;

  modport slave (
    input  req0_valid, req0_A, req0_B, req0_CTL,
    output req0_ready,
    input  req1_valid, req1_A, req1_B, req1_CTL,
    output req1_ready,
    output core_start, core_A, core_B, core_CTL,
    input  core_done, core_C, core_CTL_out,
    output rsp0_valid, rsp1_valid, rsp_C, rsp_CTL,
    input  rsp0_ready, rsp1_ready
  );

  modport master (
    output req0_valid, req0_A, req0_B, req0_CTL,
    input  req0_ready,
    output req1_valid, req1_A, req1_B, req1_CTL,
    input  req1_ready,
    input  core_start, core_A, core_B, core_CTL,
    output core_done, core_C, core_CTL_out,
    input  rsp0_valid, rsp1_valid, rsp_C, rsp_CTL,
    output rsp0_ready, rsp1_ready
  );

endinterface

// File: rtl/mtm_alu_rr_arb2.sv
// Two-input round-robin grant; ptr names the channel that wins a tie.
module mtm_alu_rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic ptr,
  output logic grant0,
  output logic grant1
);

  assign grant0 = valid0 & (~valid1 | ~ptr);
  assign grant1 = valid1 & (~valid0 | ptr);

endmodule

// File: rtl/mtm_alu_core_arbiter.sv
// Shares one mtm_Alu_core between two requesters, one operation at a time,
// with a bounded wait for the core and result routing back to the owner.
module mtm_alu_core_arbiter
  import mtm_alu_pkg::*;
#(
  parameter int               TIMEOUT     = 16,
  parameter logic [CTL_W-1:0] TIMEOUT_CTL = TIMEOUT_CTL_DEF
) (
  input logic                  clk,
  input logic                  rst,
  mtm_alu_core_arbiter_if.slave bus
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       rr_ptr;
  logic       owner;
  logic [7:0] cnt;
  logic       grant0;
  logic       grant1;
  logic       rsp_ready;

  mtm_alu_rr_arb2 u_arb (
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .ptr    (rr_ptr),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  // Ready is masked during reset so every output reads 0 while rst is high.
  assign bus.req0_ready = !rst && (state == IDLE) && grant0;
  assign bus.req1_ready = !rst && (state == IDLE) && grant1;

  assign rsp_ready = owner ? bus.rsp1_ready : bus.rsp0_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      rr_ptr         <= 1'b0;
      owner          <= 1'b0;
      cnt            <= '0;
      bus.core_start <= 1'b0;
      bus.core_A     <= '0;
      bus.core_B     <= '0;
      bus.core_CTL   <= '0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp_C      <= '0;
      bus.rsp_CTL    <= '0;
    end else begin
      bus.core_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            bus.core_A     <= grant1 ? bus.req1_A : bus.req0_A;
            bus.core_B     <= grant1 ? bus.req1_B : bus.req0_B;
            bus.core_CTL   <= grant1 ? bus.req1_CTL : bus.req0_CTL;
            owner          <= grant1;
            rr_ptr         <= ~grant1;
            bus.core_start <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A done on the final timeout cycle still wins.
          if (bus.core_done) begin
            bus.rsp_C      <= bus.core_C;
            bus.rsp_CTL    <= bus.core_CTL_out;
            bus.rsp0_valid <= ~owner;
            bus.rsp1_valid <= owner;
            state          <= RESP;
          end else if (cnt == CNT_LAST) begin
            bus.rsp_C      <= '0;
            bus.rsp_CTL    <= TIMEOUT_CTL;
            bus.rsp0_valid <= ~owner;
            bus.rsp1_valid <= owner;
            state          <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mtm_alu_core_arbiter.md
Name: mtm_alu_core_arbiter

Overview:
- Shares one mtm_Alu_core between two independent operand requesters (channel 0 and 1, e.g. two deserializer front-ends).
- Round-robin arbitration; issues one operation at a time to the core and waits for completion or timeout.
- Routes the result {C, CTL_out} back to the originating channel over a valid/ready response port.
- Sits between the deserializers and the core on the request side, and between the core and the serializers on the response side.

Parameters:
- TIMEOUT, 16: max cycles in WAIT before abandoning the operation; legal range 1..255.
- TIMEOUT_CTL, 8'hC9: CTL value returned on timeout, with C = 0.

Ports:
- clk  in  1  posedge clock
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  channel 0 operation pending
- req0_ready  out  1  channel 0 operation accepted this cycle
- req0_A  in  32  channel 0 operand A
- req0_B  in  32  channel 0 operand B
- req0_CTL  in  8  channel 0 control byte
- req1_valid / req1_ready / req1_A / req1_B / req1_CTL: same as channel 0, for channel 1
- core_start  out  1  one-cycle start pulse to the core
- core_A  out  32  operand A to the core, registered
- core_B  out  32  operand B to the core, registered
- core_CTL  out  8  control byte to the core, registered
- core_done  in  1  core result valid; sampled only in WAIT
- core_C  in  32  core result
- core_CTL_out  in  8  core status byte
- rsp0_valid  out  1  result ready for channel 0
- rsp0_ready  in  1  channel 0 consumes the result
- rsp1_valid  out  1  result ready for channel 1
- rsp1_ready  in  1  channel 1 consumes the result
- rsp_C  out  32  result data, shared by both channels
- rsp_CTL  out  8  result status, shared by both channels

Behaviour:
- Reset (async, rst=1): state=IDLE; rr_ptr=0; owner=0; timeout counter=0; all outputs 0 (core_start, req*_ready, rsp*_valid, core_A/B/CTL, rsp_C, rsp_CTL).
- Reset mid-operation aborts the operation silently; no response is ever produced for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = channel with valid set; if both valid, the channel equal to rr_ptr wins.
  - reqN_ready = (state==IDLE) && grantN. Combinational from valid; requesters must not make valid depend on ready.
  - On the accept edge: latch A/B/CTL into core_* regs, owner=N, rr_ptr = ~N, go to ISSUE.
- ISSUE: core_start=1 for exactly one cycle; go to WAIT; counter cleared.
- WAIT:
  - core_done=1: latch core_C/core_CTL_out into rsp_C/rsp_CTL; go to RESP.
  - Otherwise counter increments. When counter==TIMEOUT-1 with no done: rsp_C=0, rsp_CTL=TIMEOUT_CTL; go to RESP.
  - done arriving on the timeout cycle takes priority: the real result is used.
- RESP:
  - rsp<owner>_valid=1, the other rsp valid=0.
  - rsp_C/rsp_CTL held stable until rsp<owner>_ready=1; then go to IDLE.
  - core_done pulses outside WAIT are ignored.
- Core operands stay stable from ISSUE through RESP.
- Latency with immediate done and ready: accept at cycle T, start at T+1, done sampled at T+1+L, rsp_valid at T+2+L, next accept no earlier than T+3+L.
- At most one operation in flight; no requests are accepted outside IDLE.
- Fairness: with both channels continuously valid, grants alternate 0,1,0,1,...

Decomposition:
- Shared package mtm_alu_pkg:
  - state encoding localparams (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3)
  - TIMEOUT_CTL default
  - widths DATA_W=32, CTL_W=8
- One natural sub-module: mtm_alu_rr_arb2. Two-input round-robin grant logic (valid0, valid1, ptr -> grant0, grant1); purely combinational; the pointer stays in the parent.
- Everything else stays in a single FSM module.

Test Plan:
- Reset mid-WAIT: ch0 issues, rst pulsed asynchronously between clock edges -> all outputs 0 immediately, no rsp0_valid afterwards, next ch1 request served normally.
- Single request: ch0 A=32'h5, B=32'h3, CTL=8'h10; core answers done after 2 cycles with C=32'h8, CTL_out=8'h02 -> core_start pulses once at T+1, rsp0_valid with rsp_C=8 / rsp_CTL=02, rsp1_valid stays 0.
- Simultaneous requests after reset (rr_ptr=0): both valid -> ch0 served first, ch1 second, results routed to the correct rsp port; with both held valid for 4 ops, grant order is 0,1,0,1.
- Timeout: TIMEOUT=16, core never asserts done -> exactly 16 WAIT cycles, then rsp_valid with rsp_C=0, rsp_CTL=8'hC9; a late core_done in RESP is ignored.
- Done on the last timeout cycle: core_done at WAIT cycle 16 with C=32'hDEADBEEF -> rsp_C=32'hDEADBEEF, not a timeout frame.
- Backpressure: rsp1_ready held 0 for 10 cycles -> rsp1_valid and rsp_C stay stable; req0_ready stays 0 throughout; ch0 is accepted the cycle after the handshake completes.
